main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multi-cycle main control unit for the 16-bit CPU. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the datapath enables and the 2-bit `alu_op` code that the ALU control unit turns into a 4-bit ALU operation. It waits on a single-port memory through a ready handshake.

## Interface
- `PC_INC`, default 2: PC increment in bytes; informational only, used by the bench.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; sampled only in IDLE and at instruction end.
- `opcode` in 4: instruction bits [15:12], taken from the IR.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `zero` in 1: ALU zero flag, used in BRANCH.
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `reg_dst`, `alu_src_a` out 1 each: datapath controls.
- `alu_src_b` out 2: 00 = reg B, 01 = constant PC_INC, 10 = sign-extended immediate, 11 = shifted branch offset.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = R-format by funct, 11 = I-format by opcode.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `busy` out 1: high in every state except IDLE.

## Operation
- Opcodes:
  - 0000 R-type
  - 0001 LW
  - 0011 SW
  - 0101 BEQ
  - 0110 J
  - 1001 ADDI
  - 1010 SUBI
  - 1011 SLTI
  - 0010 SLL
  - all others illegal.
- Moore FSM. The only Mealy terms are `pc_write` and `ir_write` in FETCH and the state advance on `mem_ready`. Every output is 0 unless listed for the state below.
- IDLE: all outputs 0.
  - → FETCH if `enable`=1, else stay.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` = `mem_ready`.
  - → DECODE when `mem_ready`=1, else stay.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target precompute). Next state by opcode:
  - LW/SW → MEM_ADDR
  - R-type → EXEC_R
  - ADDI/SUBI/SLTI/SLL → EXEC_I
  - BEQ → BRANCH
  - J → JUMP
  - illegal: assert `illegal_op`, → FETCH or IDLE per `enable`.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - → MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_read`=1, `i_or_d`=1.
  - → MEM_WB on `mem_ready`, else hold.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - Holds until `mem_ready`, then ends the instruction.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. → ALU_WB.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. → ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0.
  - `reg_dst`=1 for R-type, 0 for I-format. The opcode is the one latched at DECODE.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - The PC is taken when `zero`=1; the datapath ANDs `zero` with `pc_write_cond`.
- JUMP: `pc_write`=1, `pc_source`=10.
- Instruction end is the exit of MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP or the illegal path: → FETCH if `enable`=1, else IDLE.
- The opcode is latched into an internal register at DECODE. Later states use the latched copy, so a mid-instruction change of the `opcode` input is ignored.

## Timing
- Reset: asynchronous assert forces state to IDLE and every output to 0 immediately. Release is synchronous to the next `clk` edge.
- Reset mid-instruction abandons the instruction. No memory strobe survives reset.
- Cycles with zero-wait memory:
  - R/I-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
  - illegal: 2
- Each memory wait cycle adds one cycle, in FETCH, MEM_READ or MEM_WRITE.
- `mem_read`/`mem_write` stay asserted and stable until the cycle `mem_ready`=1 is sampled. A `mem_ready` seen in any other state is ignored.
- `illegal_op` is high for exactly one cycle.

## Structure
- Package `cpu16_pkg` holds:
  - opcode localparams
  - `alu_op` encodings (00/01/10/11)
  - `alu_src_b` and `pc_source` encodings
  - state enumeration, 4-bit, shared with the debug and trace logic.
- One sub-module, `ctrl_output_decode`: purely combinational map from (state, latched opcode, `mem_ready`) to the output vector. The FSM register and next-state logic stay in `main_control_fsm`.

## Test plan
- Reset held with `enable`=1: all outputs 0 and `busy`=0. After release with `enable`=1: FETCH with `mem_read`=1 on the first edge.
- ADDI (1001), zero-wait: states FETCH, DECODE, EXEC_I, ALU_WB. `alu_op`=11 in EXEC_I; `reg_write`=1 with `reg_dst`=0 on cycle 4.
- LW (0001) with `mem_ready` low for 3 cycles in MEM_READ: `mem_read` and `i_or_d` held for 4 cycles. MEM_WB is entered on the cycle after `mem_ready`=1; total 8 cycles.
- BEQ (0101): with `zero`=1, BRANCH shows `pc_write_cond`=1, `pc_source`=01, `alu_op`=01. Repeat with `zero`=0: same outputs; instruction length is 3 cycles either way.
- Opcode 1111: `illegal_op` pulses once in DECODE, then back to FETCH. `reg_write`, `mem_write` and `pc_write` are never asserted after the fetch.
- `reset_n` dropped during MEM_WRITE: `mem_write` falls in the same cycle, without waiting for a clock. After release with `enable`=0 the unit stays in IDLE.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared encodings for the 16-bit CPU control path: opcodes, ALU/mux selects,
// the control state enumeration and the datapath control bundle.
package cpu16_pkg;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_LW    = 4'b0001;
   localparam logic [3:0] OP_SLL   = 4'b0010;
   localparam logic [3:0] OP_SW    = 4'b0011;
   localparam logic [3:0] OP_BEQ   = 4'b0101;
   localparam logic [3:0] OP_J     = 4'b0110;
   localparam logic [3:0] OP_ADDI  = 4'b1001;
   localparam logic [3:0] OP_SUBI  = 4'b1010;
   localparam logic [3:0] OP_SLTI  = 4'b1011;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_RFMT = 2'b10;
   localparam logic [1:0] ALU_IFMT = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_INC  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_EXEC_I    = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
      logic       busy;
   } ctrl_t;

   function automatic logic is_iformat(input logic [3:0] op);
      return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI) || (op == OP_SLL);
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      return is_iformat(op) || (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J);
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from control state, effective opcode and mem_ready to the
// datapath control bundle. Only FETCH looks at mem_ready.
module ctrl_output_decode
   import cpu16_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] op,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl      = '0;
      ctrl.busy = (state != S_IDLE);
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_INC;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is examined
            ctrl.alu_src_b  = SRCB_BOFF;
            ctrl.alu_op     = ALU_ADD;
            ctrl.illegal_op = !is_legal(op);
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_RFMT;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_IFMT;
         end
         S_ALU_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = (op == OP_RTYPE);
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: sequences fetch/decode/execute/memory/write-back
// and waits on single-port memory through mem_ready.
module main_control_fsm
   import cpu16_pkg::*;
#(
   parameter int PC_INC = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [3:0] opcode,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       busy
);

   state_t     state, state_nxt, end_state;
   logic [3:0] opcode_q, op_eff;
   ctrl_t      ctrl;

   // zero is gated with pc_write_cond in the datapath; PC_INC sizes the adder constant there
   logic unused_inputs;
   assign unused_inputs = zero ^ PC_INC[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (state == S_DECODE) opcode_q <= opcode;
   end

   // DECODE sees the live IR opcode; every later state uses the latched copy
   assign op_eff    = (state == S_DECODE) ? opcode : opcode_q;
   assign end_state = enable ? S_FETCH : S_IDLE;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (enable) state_nxt = S_FETCH;
         S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            if ((opcode == OP_LW) || (opcode == OP_SW)) state_nxt = S_MEM_ADDR;
            else if (opcode == OP_RTYPE)                state_nxt = S_EXEC_R;
            else if (is_iformat(opcode))                state_nxt = S_EXEC_I;
            else if (opcode == OP_BEQ)                  state_nxt = S_BRANCH;
            else if (opcode == OP_J)                    state_nxt = S_JUMP;
            else                                        state_nxt = end_state;
         end
         S_MEM_ADDR:  state_nxt = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) state_nxt = end_state;
         S_EXEC_R,
         S_EXEC_I:    state_nxt = S_ALU_WB;
         S_MEM_WB,
         S_ALU_WB,
         S_BRANCH,
         S_JUMP:      state_nxt = end_state;
         default:     state_nxt = S_IDLE;
      endcase
   end

   ctrl_output_decode u_decode (
      .state     (state),
      .op        (op_eff),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign ir_write      = ctrl.ir_write;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign reg_dst       = ctrl.reg_dst;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign illegal_op    = ctrl.illegal_op;
   assign busy          = ctrl.busy;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: walks each instruction class cycle by
// cycle and compares the full control vector against hand-derived values.
module tb_main_control_fsm;

   logic       clk = 1'b0;
   logic       reset_n, enable, mem_ready, zero;
   logic [3:0] opcode;
   logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op, busy;
   logic [1:0] alu_src_b, alu_op, pc_source;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   main_control_fsm #(.PC_INC(2)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .opcode(opcode),
      .mem_ready(mem_ready), .zero(zero),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .busy(busy)
   );

   // Field packer: pcw pcwc irw iord mrd mwr m2r rw rdst asa | asb aop psrc | ill busy
   function automatic logic [17:0] o(input logic pcw, pcwc, irw, iord, mrd, mwr, m2r, rw,
                                     rdst, asa, input logic [1:0] asb, aop, psrc,
                                     input logic ill, bsy);
      return {pcw, pcwc, irw, iord, mrd, mwr, m2r, rw, rdst, asa, asb, aop, psrc, ill, bsy};
   endfunction

   logic [17:0] obs;
   assign obs = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                 reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, busy};

   localparam logic [17:0] E_IDLE = '0;
   localparam logic [17:0] E_F0   = o(0,0,0,0,1,0,0,0,0,0, 2'b01,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_F1   = o(1,0,1,0,1,0,0,0,0,0, 2'b01,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_DEC  = o(0,0,0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_DILL = o(0,0,0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 1,1);
   localparam logic [17:0] E_MADR = o(0,0,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_MRD  = o(0,0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_MWB  = o(0,0,0,0,0,0,1,1,0,0, 2'b00,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_MWR  = o(0,0,0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_EXR  = o(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00, 0,1);
   localparam logic [17:0] E_EXI  = o(0,0,0,0,0,0,0,0,0,1, 2'b10,2'b11,2'b00, 0,1);
   localparam logic [17:0] E_WBR  = o(0,0,0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_WBI  = o(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00, 0,1);
   localparam logic [17:0] E_BR   = o(0,1,0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 0,1);
   localparam logic [17:0] E_JMP  = o(1,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 0,1);

   task automatic chk(input string tag, input logic [17:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here, checks follow #1 later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 4'b0000;
      #3;
      chk("reset_pre_clock", E_IDLE);
      tick(); tick(); #1;
      chk("reset_held_enable", E_IDLE);
      @(negedge clk); reset_n = 1'b1;

      // ADDI, zero-wait
      tick(); #1;                       chk("addi_fetch_wait", E_F0);
      mem_ready = 1'b1; opcode = 4'b1001; #1; chk("addi_fetch_ready", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("addi_decode", E_DEC);
      tick(); opcode = 4'b0000; #1;     chk("addi_exec_i", E_EXI);
      tick(); #1;                       chk("addi_alu_wb_latched", E_WBI);

      // LW with three wait cycles in MEM_READ
      tick(); mem_ready = 1'b1; opcode = 4'b0001; #1; chk("lw_fetch", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("lw_decode", E_DEC);
      tick(); #1;                       chk("lw_mem_addr", E_MADR);
      tick(); #1;                       chk("lw_mem_read_w1", E_MRD);
      tick(); #1;                       chk("lw_mem_read_w2", E_MRD);
      tick(); #1;                       chk("lw_mem_read_w3", E_MRD);
      tick(); mem_ready = 1'b1; #1;     chk("lw_mem_read_done", E_MRD);
      tick(); mem_ready = 1'b0; #1;     chk("lw_mem_wb", E_MWB);

      // BEQ taken then not taken; both 3 cycles
      tick(); mem_ready = 1'b1; opcode = 4'b0101; #1; chk("beq1_fetch", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("beq1_decode", E_DEC);
      tick(); zero = 1'b1; #1;          chk("beq1_branch_z1", E_BR);
      tick(); mem_ready = 1'b1; #1;     chk("beq2_fetch", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("beq2_decode", E_DEC);
      tick(); zero = 1'b0; #1;          chk("beq2_branch_z0", E_BR);
      tick(); #1;                       chk("beq2_next_fetch", E_F0);

      // Illegal opcode 1111
      mem_ready = 1'b1; opcode = 4'b1111; #1; chk("ill_fetch", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("ill_decode_pulse", E_DILL);
      tick(); #1;                       chk("ill_back_fetch", E_F0);
      tick(); #1;                       chk("ill_still_fetch", E_F0);

      // R-type: reg_dst=1 in ALU_WB
      mem_ready = 1'b1; opcode = 4'b0000; #1; chk("r_fetch", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("r_decode", E_DEC);
      tick(); opcode = 4'b1001; #1;     chk("r_exec", E_EXR);
      tick(); #1;                       chk("r_alu_wb", E_WBR);

      // J, ending with enable=0 -> IDLE
      tick(); mem_ready = 1'b1; opcode = 4'b0110; #1; chk("j_fetch", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("j_decode", E_DEC);
      tick(); enable = 1'b0; #1;        chk("j_jump", E_JMP);
      tick(); #1;                       chk("j_end_idle", E_IDLE);
      tick(); enable = 1'b1; #1;        chk("idle_enable0_hold", E_IDLE);

      // SW, reset dropped while waiting in MEM_WRITE
      tick(); mem_ready = 1'b1; opcode = 4'b0011; #1; chk("sw_fetch", E_F1);
      tick(); mem_ready = 1'b0; #1;     chk("sw_decode", E_DEC);
      tick(); #1;                       chk("sw_mem_addr", E_MADR);
      tick(); #1;                       chk("sw_mem_write_w1", E_MWR);
      tick(); #1;                       chk("sw_mem_write_w2", E_MWR);
      #1; reset_n = 1'b0; #1;           chk("sw_async_reset", E_IDLE);
      enable = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      tick(); #1;                       chk("post_reset_idle1", E_IDLE);
      tick(); mem_ready = 1'b1; #1;     chk("post_reset_idle2", E_IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
